// File: rtl/pipe_fetch.sv
// ---------------------------------------------------------------------------
// pipe_fetch -- Y86-64 fetch stage
//
// Holds the PC and reads 8-byte words from instruction memory over a
// req/ack port. One instruction (1, 2, 9 or 10 bytes) is assembled from
// one or two reads, decoded, and presented with a valid flag to the
// fetch/decode pipeline register. A redirect from pipeline control has
// priority over everything else. A read that is squashed by a redirect
// is not abandoned; it is drained and its data is thrown away.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   imem_req/imem_addr    read request and byte address (held until ack)
//   imem_ack/imem_rdata   read completion and data (byte 0 in [7:0])
//   imem_err              address error, qualified by imem_ack
//   d_stall               downstream cannot accept the presented instruction
//   redir_valid/redir_pc  redirect request and target
//   f_valid               f_* hold a complete instruction
//   f_status              1=AOK 2=HLT 3=ADR 4=INS
//   f_icode..f_rB         decoded fields
//   f_valC, f_valP        constant word, PC + length
//   f_pred_pc, f_pc       predicted next PC, address of this instruction
// ---------------------------------------------------------------------------
module pipe_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [63:0] imem_rdata,
    input  logic        imem_err,
    input  logic        d_stall,
    input  logic        redir_valid,
    input  logic [63:0] redir_pc,
    output logic        f_valid,
    output logic [2:0]  f_status,
    output logic [3:0]  f_icode,
    output logic [3:0]  f_ifun,
    output logic [3:0]  f_rA,
    output logic [3:0]  f_rB,
    output logic [63:0] f_valC,
    output logic [63:0] f_valP,
    output logic [63:0] f_pred_pc,
    output logic [63:0] f_pc
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_F0     = 3'd1,
        S_F1     = 3'd2,
        S_VALID  = 3'd3,
        S_DRAIN  = 3'd4,
        S_HALTED = 3'd5
    } state_t;

    localparam logic [2:0] ST_AOK = 3'd1;
    localparam logic [2:0] ST_HLT = 3'd2;
    localparam logic [2:0] ST_ADR = 3'd3;
    localparam logic [2:0] ST_INS = 3'd4;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      r_state;
    logic [63:0] r_pc;
    logic [63:0] r_addr;     // address of the current/outstanding read
    logic [63:0] r_buf;      // bytes 0..7 of a long instruction
    logic [2:0]  r_status;
    logic [3:0]  r_icode;
    logic [3:0]  r_ifun;
    logic [3:0]  r_ra;
    logic [3:0]  r_rb;
    logic [63:0] r_valc;
    logic [63:0] r_valp;
    logic [63:0] r_pred;

    state_t      w_state_next;
    logic [63:0] w_pc_next;
    logic [63:0] w_addr_next;
    logic        w_capture;
    logic        w_buf_load;
    logic        w_ack;

    // ------------------------------------------------------------------
    // Decode of the bytes available in the completing cycle
    // ------------------------------------------------------------------
    logic [79:0] w_bytes;
    logic [3:0]  w_icode;
    logic [3:0]  w_ifun;
    logic [3:0]  w_len;
    logic [2:0]  w_dec_status;
    logic [3:0]  w_dec_icode;
    logic [3:0]  w_dec_ifun;
    logic [3:0]  w_dec_ra;
    logic [3:0]  w_dec_rb;
    logic [63:0] w_dec_valc;
    logic [63:0] w_dec_valp;
    logic [63:0] w_dec_pred;

    assign w_ack = imem_req && imem_ack;

    // In F1 the first word comes from the buffer and the second read
    // supplies bytes 8..9; in F0 the read data is the whole instruction.
    assign w_bytes = (r_state == S_F1) ? {imem_rdata[15:0], r_buf}
                                       : {16'h0, imem_rdata};
    assign w_icode = w_bytes[7:4];
    assign w_ifun  = w_bytes[3:0];

    always_comb begin
        w_len = 4'd1;
        case (w_icode)
            4'h0, 4'h1, 4'h9:       w_len = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB: w_len = 4'd2;
            4'h7, 4'h8:             w_len = 4'd9;
            4'h3, 4'h4, 4'h5:       w_len = 4'd10;
            default:                w_len = 4'd1;  // illegal icode
        endcase
    end

    always_comb begin
        w_dec_icode = w_icode;
        w_dec_ifun  = w_ifun;
        w_dec_ra    = 4'hF;
        w_dec_rb    = 4'hF;
        w_dec_valc  = 64'h0;
        w_dec_valp  = r_pc + {60'h0, w_len};
        w_dec_pred  = w_dec_valp;

        if (w_len >= 4'd2) begin
            w_dec_ra = w_bytes[15:12];
            w_dec_rb = w_bytes[11:8];
        end
        case (w_icode)
            4'h7, 4'h8:       w_dec_valc = w_bytes[71:8];
            4'h3, 4'h4, 4'h5: w_dec_valc = w_bytes[79:16];
            default:          w_dec_valc = 64'h0;
        endcase
        // Jumps and calls are predicted taken.
        if (w_icode == 4'h7 || w_icode == 4'h8) begin
            w_dec_pred = w_dec_valc;
        end

        if (imem_err) begin
            w_dec_status = ST_ADR;
            // A faulting fetch is presented as a harmless nop-like shell.
            w_dec_icode  = 4'h1;
            w_dec_ifun   = 4'h0;
            w_dec_ra     = 4'hF;
            w_dec_rb     = 4'hF;
            w_dec_valc   = 64'h0;
            w_dec_pred   = w_dec_valp;
        end else if (w_icode > 4'hB) begin
            w_dec_status = ST_INS;
        end else if (w_icode == 4'h0) begin
            w_dec_status = ST_HLT;
        end else begin
            w_dec_status = ST_AOK;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_addr_next  = r_addr;
        w_capture    = 1'b0;
        w_buf_load   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_state_next = S_F0;
                w_addr_next  = r_pc;
            end
            S_F0: begin
                if (w_ack) begin
                    if (imem_err || w_len <= 4'd8) begin
                        w_state_next = S_VALID;
                        w_capture    = 1'b1;
                    end else begin
                        w_state_next = S_F1;
                        w_buf_load   = 1'b1;
                        w_addr_next  = r_pc + 64'd8;
                    end
                end
            end
            S_F1: begin
                if (w_ack) begin
                    w_state_next = S_VALID;
                    w_capture    = 1'b1;
                end
            end
            S_VALID: begin
                if (!d_stall) begin
                    if (r_status == ST_AOK) begin
                        w_state_next = S_F0;
                        w_pc_next    = r_pred;
                        w_addr_next  = r_pred;
                    end else begin
                        w_state_next = S_HALTED;
                    end
                end
            end
            S_DRAIN: begin
                // Squashed read completes; its data is dropped.
                if (w_ack) begin
                    w_state_next = S_F0;
                    w_addr_next  = r_pc;
                end
            end
            S_HALTED: begin
                w_state_next = S_HALTED;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // Redirect overrides everything. A read still in flight keeps its
        // address on the bus until the memory acknowledges it.
        if (redir_valid) begin
            w_pc_next  = redir_pc;
            w_capture  = 1'b0;
            w_buf_load = 1'b0;
            if ((r_state == S_F0 || r_state == S_F1 || r_state == S_DRAIN) && !w_ack) begin
                w_state_next = S_DRAIN;
                w_addr_next  = r_addr;
            end else begin
                w_state_next = S_F0;
                w_addr_next  = redir_pc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_PC;
            r_addr   <= RESET_PC;
            r_buf    <= 64'h0;
            r_status <= 3'd0;
            r_icode  <= 4'h0;
            r_ifun   <= 4'h0;
            r_ra     <= 4'hF;
            r_rb     <= 4'hF;
            r_valc   <= 64'h0;
            r_valp   <= 64'h0;
            r_pred   <= 64'h0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_addr  <= w_addr_next;
            if (w_buf_load) begin
                r_buf <= imem_rdata;
            end
            if (w_capture) begin
                r_status <= w_dec_status;
                r_icode  <= w_dec_icode;
                r_ifun   <= w_dec_ifun;
                r_ra     <= w_dec_ra;
                r_rb     <= w_dec_rb;
                r_valc   <= w_dec_valc;
                r_valp   <= w_dec_valp;
                r_pred   <= w_dec_pred;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign imem_req  = (r_state == S_F0) || (r_state == S_F1) || (r_state == S_DRAIN);
    assign imem_addr = r_addr;

    assign f_valid   = (r_state == S_VALID);
    assign f_status  = r_status;
    assign f_icode   = r_icode;
    assign f_ifun    = r_ifun;
    assign f_rA      = r_ra;
    assign f_rB      = r_rb;
    assign f_valC    = r_valc;
    assign f_valP    = r_valp;
    assign f_pred_pc = r_pred;
    assign f_pc      = r_pc;

endmodule

// File: tb/tb_pipe_fetch.sv
// ---------------------------------------------------------------------------
// tb_pipe_fetch -- directed bench for pipe_fetch
//
// A byte-array memory model answers reads with a programmable wait count
// and an optional faulting address. Expected instructions are pushed to a
// scoreboard queue as each program step is set up and popped when the
// DUT presents f_valid.
// ---------------------------------------------------------------------------
module tb_pipe_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [63:0] imem_rdata;
    logic        imem_err;
    logic        d_stall;
    logic        redir_valid;
    logic [63:0] redir_pc;
    logic        f_valid;
    logic [2:0]  f_status;
    logic [3:0]  f_icode;
    logic [3:0]  f_ifun;
    logic [3:0]  f_rA;
    logic [3:0]  f_rB;
    logic [63:0] f_valC;
    logic [63:0] f_valP;
    logic [63:0] f_pred_pc;
    logic [63:0] f_pc;

    pipe_fetch #(.RESET_PC(64'h0)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .imem_err   (imem_err),
        .d_stall    (d_stall),
        .redir_valid(redir_valid),
        .redir_pc   (redir_pc),
        .f_valid    (f_valid),
        .f_status   (f_status),
        .f_icode    (f_icode),
        .f_ifun     (f_ifun),
        .f_rA       (f_rA),
        .f_rB       (f_rB),
        .f_valC     (f_valC),
        .f_valP     (f_valP),
        .f_pred_pc  (f_pred_pc),
        .f_pc       (f_pc)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  mem [0:511];
    int          lat      = 0;
    int          wcnt     = 0;
    logic        err_en   = 1'b0;
    logic [63:0] err_addr = 64'h0;

    typedef struct {
        logic [2:0]  st;
        logic [3:0]  ic;
        logic [3:0]  fn;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
        logic [63:0] pred;
        logic [63:0] pc;
        bit          chk_p;
    } exp_t;

    exp_t sb[$];

    // Memory responder: decides ack/data/err at the falling edge.
    initial begin
        logic [8:0] a;
        imem_ack   = 1'b0;
        imem_rdata = 64'h0;
        imem_err   = 1'b0;
        forever begin
            @(negedge clk);
            if (imem_ack) wcnt = 0;  // previous read completed at last edge
            if (imem_req) begin
                imem_ack = (wcnt >= lat);
                if (!imem_ack) wcnt++;
            end else begin
                imem_ack = 1'b0;
                wcnt     = 0;
            end
            for (int b = 0; b < 8; b++) begin
                a = imem_addr[8:0] + 9'(b);
                imem_rdata[8*b +: 8] = mem[a];
            end
            imem_err = err_en && (imem_addr == err_addr);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] fn,
                        input logic [3:0] ra, input logic [3:0] rb, input logic [63:0] valc,
                        input logic [63:0] valp, input logic [63:0] pred, input logic [63:0] pc,
                        input bit chk_p);
        exp_t e;
        e.st = st; e.ic = ic; e.fn = fn; e.ra = ra; e.rb = rb;
        e.valc = valc; e.valp = valp; e.pred = pred; e.pc = pc; e.chk_p = chk_p;
        sb.push_back(e);
    endtask

    task automatic check_instr(input string tag);
        exp_t e;
        chk({tag, ".valid"}, 64'(f_valid), 64'd1);
        chk({tag, ".sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, ".status"}, 64'(f_status), 64'(e.st));
            chk({tag, ".icode"},  64'(f_icode),  64'(e.ic));
            chk({tag, ".ifun"},   64'(f_ifun),   64'(e.fn));
            chk({tag, ".rA"},     64'(f_rA),     64'(e.ra));
            chk({tag, ".rB"},     64'(f_rB),     64'(e.rb));
            chk({tag, ".valC"},   f_valC,        e.valc);
            chk({tag, ".pc"},     f_pc,          e.pc);
            if (e.chk_p) begin
                chk({tag, ".valP"}, f_valP,    e.valp);
                chk({tag, ".pred"}, f_pred_pc, e.pred);
            end
            $display("instr %s pc=%0h icode=%0h status=%0d valC=%0h valP=%0h",
                     tag, f_pc, f_icode, f_status, f_valC, f_valP);
        end
    endtask

    task automatic chk_req(input string tag, input logic req, input logic [63:0] addr);
        chk({tag, ".req"}, 64'(imem_req), 64'(req));
        if (req) chk({tag, ".addr"}, imem_addr, addr);
        chk({tag, ".fvalid0"}, 64'(f_valid), 64'd0);
        $display("step %s req=%0b addr=%0h", tag, imem_req, imem_addr);
    endtask

    initial begin
        rst = 1'b0; d_stall = 1'b0; redir_valid = 1'b0; redir_pc = 64'h0;
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        // irmovq $10, %rdx at 0
        mem[9'h000] = 8'h30; mem[9'h001] = 8'hF2; mem[9'h002] = 8'h0A;
        // jmp 0x100 at 0x20
        mem[9'h020] = 8'h70; mem[9'h021] = 8'h00; mem[9'h022] = 8'h01;
        // rrmovq %rcx, %rdx at 0x100
        mem[9'h100] = 8'h20; mem[9'h101] = 8'h12;
        // illegal byte at 0x40, halt at 0x60
        mem[9'h040] = 8'hC0;
        mem[9'h060] = 8'h00;
        // irmovq $5, %rbx at 0x80 (second word will fault)
        mem[9'h080] = 8'h30; mem[9'h081] = 8'hF3; mem[9'h082] = 8'h05;

        #1 rst = 1'b1;
        #2;
        chk("rst.valid",  64'(f_valid),  64'd0);
        chk("rst.status", 64'(f_status), 64'd0);
        chk("rst.icode",  64'(f_icode),  64'd0);
        chk("rst.ifun",   64'(f_ifun),   64'd0);
        chk("rst.rA",     64'(f_rA),     64'hF);
        chk("rst.rB",     64'(f_rB),     64'hF);
        chk("rst.valC",   f_valC,        64'h0);
        chk("rst.valP",   f_valP,        64'h0);
        chk("rst.pred",   f_pred_pc,     64'h0);
        chk("rst.pc",     f_pc,          64'h0);
        chk("rst.req",    64'(imem_req), 64'd0);
        chk("rst.addr",   imem_addr,     64'h0);
        $display("step reset checked");
        @(posedge clk); #1 rst = 1'b0;

        // irmovq: F0 at 0, F1 at 8, then presented
        push(3'd1, 4'h3, 4'h0, 4'hF, 4'h2, 64'd10, 64'd10, 64'd10, 64'h0, 1'b1);
        tick(); chk_req("irm.f0", 1'b1, 64'h0);
        tick(); chk_req("irm.f1", 1'b1, 64'h8);
        tick(); check_instr("irmovq");
        tick(); chk_req("irm.next", 1'b1, 64'hA);

        // redirect while F0 is being acked -> new F0 at 0x20
        redir_valid = 1'b1; redir_pc = 64'h20;
        tick(); redir_valid = 1'b0;
        chk_req("redir20", 1'b1, 64'h20);

        // jmp 0x100: rA/rB come from byte 1 (0x00)
        push(3'd1, 4'h7, 4'h0, 4'h0, 4'h0, 64'h100, 64'h29, 64'h100, 64'h20, 1'b1);
        tick(); chk_req("jxx.f1", 1'b1, 64'h28);
        tick(); check_instr("jxx");
        tick(); chk_req("jxx.next", 1'b1, 64'h100);

        // rrmovq with stall held for three cycles in VALID
        push(3'd1, 4'h2, 4'h0, 4'h1, 4'h2, 64'h0, 64'h102, 64'h102, 64'h100, 1'b1);
        d_stall = 1'b1;
        tick(); check_instr("rrmovq");
        chk("stall.req0", 64'(imem_req), 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall.valid", 64'(f_valid),  64'd1);
            chk("stall.valP",  f_valP,        64'h102);
            chk("stall.rA",    64'(f_rA),     64'h1);
            chk("stall.rB",    64'(f_rB),     64'h2);
            chk("stall.pc",    f_pc,          64'h100);
            chk("stall.req",   64'(imem_req), 64'd0);
            $display("step stall cycle %0d valid=%0b req=%0b", k, f_valid, imem_req);
        end
        d_stall = 1'b0;
        tick(); chk_req("stall.release", 1'b1, 64'h102);

        // slow memory; redirect on the second wait cycle, read drained
        lat = 5;
        tick(); chk_req("slow.wait2", 1'b1, 64'h102);
        redir_valid = 1'b1; redir_pc = 64'h40;
        tick(); redir_valid = 1'b0;
        chk_req("slow.drain", 1'b1, 64'h102);
        for (int k = 0; k < 3; k++) begin
            tick(); chk_req("slow.hold", 1'b1, 64'h102);
        end
        lat = 0;
        tick(); chk_req("slow.new", 1'b1, 64'h40);

        // illegal instruction -> INS, then halted
        push(3'd4, 4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'h41, 64'h41, 64'h40, 1'b1);
        tick(); check_instr("ins");
        for (int k = 0; k < 3; k++) begin
            tick(); chk_req("ins.halted", 1'b0, 64'h0);
        end
        redir_valid = 1'b1; redir_pc = 64'h0;
        tick(); redir_valid = 1'b0;
        chk_req("resume0", 1'b1, 64'h0);
        redir_valid = 1'b1; redir_pc = 64'h60;
        tick(); redir_valid = 1'b0;
        chk_req("redir60", 1'b1, 64'h60);

        // halt
        push(3'd2, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h61, 64'h61, 64'h60, 1'b1);
        tick(); check_instr("hlt");
        tick(); chk_req("hlt.halted", 1'b0, 64'h0);
        tick(); chk_req("hlt.halted2", 1'b0, 64'h0);

        // address error on the second read of a long instruction
        err_en = 1'b1; err_addr = 64'h88;
        redir_valid = 1'b1; redir_pc = 64'h80;
        tick(); redir_valid = 1'b0;
        chk_req("adr.f0", 1'b1, 64'h80);
        push(3'd3, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 64'h0, 64'h80, 1'b0);
        tick(); chk_req("adr.f1", 1'b1, 64'h88);
        tick(); check_instr("adr");
        tick(); chk_req("adr.halted", 1'b0, 64'h0);

        chk("sb.empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_fetch.md
# pipe_fetch

Fetch stage of the Y86-64 pipeline.
- Holds the PC and reads instruction bytes from instruction memory over a req/ack port.
- Assembles and decodes one instruction (1, 2, 9 or 10 bytes) and predicts the next PC.
- Presents the fields, with a valid flag, to the fetch/decode pipeline register.
- Honours downstream stall and redirects (mispredict, `ret`) from pipeline control.

## Interface
Parameters:
- RESET_PC, 64'h0, PC loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  read request; combinational from state.
- imem_addr  out  64  byte address of the 8-byte read.
- imem_ack  in  1  read completes on an edge where imem_req && imem_ack.
- imem_rdata  in  64  bytes at imem_addr..+7; byte 0 in bits [7:0].
- imem_err  in  1  address error; qualified by imem_ack.
- d_stall  in  1  downstream cannot accept this cycle.
- redir_valid  in  1  redirect request.
- redir_pc  in  64  redirect target.
- f_valid  out  1  outputs below hold a complete instruction.
- f_status  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS.
- f_icode, f_ifun, f_rA, f_rB  out  4 each  decoded fields.
- f_valC  out  64  constant word.
- f_valP  out  64  PC + length.
- f_pred_pc  out  64  predicted next PC.
- f_pc  out  64  address of this instruction.

## Operation
States:
- IDLE: reset state.
- F0: read at PC.
- F1: read at PC+8.
- VALID: instruction presented.
- DRAIN: squashed read outstanding.
- HALTED: fetch stopped.

imem_req=1 in F0, F1 and DRAIN; imem_addr = PC in F0, PC+8 in F1. Once raised, imem_req and imem_addr hold until ack.

Instruction length by byte-0 icode:
- 0, 1, 9 → 1 byte.
- 2, 6, A, B → 2 bytes.
- 7, 8 → 9 bytes.
- 3, 4, 5 → 10 bytes.
- icode > B → INS, treated as 1 byte.

Decode:
- rA = byte1[7:4], rB = byte1[3:0] when length ≥ 2; otherwise both 4'hF.
- valC = bytes 1..8 for icode 7/8, bytes 2..9 for icode 3/4/5, else 0.
- valP = PC + length, 64-bit wraparound.
- pred_pc = valC for icode 7 and 8, else valP.

Transitions:
- IDLE → F0 unconditionally.
- F0 on ack, length ≤ 8 or imem_err → VALID.
- F0 on ack, length > 8 → F1; bytes 0..7 kept in the buffer.
- F1 on ack → VALID; rdata[15:0] supplies bytes 8..9.
- VALID with !d_stall (accept):
  - status AOK → F0 with PC ← pred_pc.
  - otherwise → HALTED.
- HALTED: no requests.

Status:
- imem_err on either read → ADR, with f_icode=1, f_ifun=0, f_rA=f_rB=F, f_valC=0.
- Else icode > B → INS (icode kept).
- Else icode 0 → HLT.
- Else AOK.

Redirect (redir_valid=1; highest priority, any state):
- PC ← redir_pc and f_valid=0 next cycle.
- State next:
  - F0/F1 without ack that cycle → DRAIN.
  - F0/F1 with ack → F0 (data discarded).
  - DRAIN without ack → stays DRAIN.
  - Any other case → F0.
- An instruction presented in VALID in the same cycle as a redirect counts as not accepted; downstream squashes it.

DRAIN on ack → F0; the returned data is discarded.

## Timing
- Reset (async):
  - State IDLE, PC=RESET_PC.
  - All f_* outputs 0 except f_rA=f_rB=4'hF.
  - imem_req=0, imem_addr=RESET_PC.
- Outputs are registered or decoded from registered buffers; stable for the whole VALID dwell.
- Zero-wait memory (ack tied 1):
  - Short instruction: F0 1 cycle, then f_valid.
  - Long instruction: F0 + F1, f_valid on the third cycle.
  - Throughput: one short instruction per 2 cycles.
- Each extra wait cycle on ack adds one cycle.
- Stall in VALID: state and outputs frozen, imem_req=0.
- rst asserted mid-read: request dropped immediately; memory must tolerate an abandoned request.

## Test plan
- irmovq at 0 (30 F2 0A 00..00), ack tied 1:
  - Cycle 1 after reset: F0 addr 0; then F1 addr 8.
  - Then f_valid with icode 3, ifun 0, rA F, rB 2, valC 10, valP 10, pred 10, status AOK.
  - Next F0 addr 10.
- jXX at 0x20 (70 00 01 00 00 00 00 00 00):
  - valC 0x100, valP 0x29, pred 0x100.
  - Next F0 addr 0x100.
- rrmovq 20 12 with d_stall held 3 cycles:
  - f_valid and all fields constant, imem_req=0 throughout.
  - Advances to F0 addr PC+2 one cycle after stall drops.
- ack latency 5, redirect to 0x40 on second wait cycle:
  - imem_req stays high at the old address until ack; data discarded.
  - Next request at 0x40; f_valid never asserted for the old instruction.
- Byte C0 at PC:
  - INS presented; after accept HALTED, no further imem_req.
  - redir_valid to 0 resumes F0 at 0.
- Byte 00 → HLT then HALTED.
- irmovq with imem_err on the F1 ack → ADR, icode 1, ifun 0, valC 0.
